mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath. It replaces the single-cycle combinational decoder with an FSM that sequences fetch, decode, execute, memory and write-back.
- It handshakes with instruction and data memory, which may insert wait states.
- It drives the same PC, register-file, ALU, extender and write-back mux controls, and adds IR/PC write enables and memory request strobes.
- Op/Funct come from the datapath IR, which is held stable from DECODE until the next IRWrite.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, valid in EXEC
im_rdy  in  1  instruction memory data valid
dm_rdy  in  1  data memory access complete
im_req  out  1  instruction fetch request
dm_req  out  1  data memory request
MemWrite  out  1  data request is a store (qualifies dm_req)
IRWrite  out  1  load IR
PCWrite  out  1  update PC with NPC
NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr
RegWrite  out  1  register file write
GPRSel  out  2  00 rd, 01 rt, 10 r31
WDSel  out  2  00 ALU, 01 MEM, 10 PC
EXTOp  out  1  1 = sign extend
ALUSrc  out  1  B operand = extended immediate
ALUOp  out  6  00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 SLT, 06 SLTU, 07 XOR, 08 NOR, 09 SLL, 0A SRL, 0B SLLV, 0C SRLV, 0D SRAV, 0E LUI, 11 SRA
state  out  3  current state, for debug
instr_done  out  1  one-cycle pulse on an instruction's final cycle
illegal  out  1  one-cycle pulse when an unsupported encoding is decoded
retired  out  CNT_W  count of instr_done pulses

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. The state register is reset asynchronously to IDLE.
- While rstn=0:
  - state=IDLE, retired=0.
  - All outputs are 0.
- IDLE:
  - All strobes are 0.
  - Goes to FETCH unconditionally on the next clock.
- FETCH:
  - im_req=1 and the FSM holds until im_rdy=1.
  - In the im_rdy cycle: IRWrite=1, PCWrite=1, NPCOp=00; next state DECODE.
- DECODE:
  - No strobes; the register file is read.
  - Unsupported Op, or Op=0 with an unsupported Funct: illegal=1 and instr_done=1 for one cycle, next state FETCH, no architectural write.
  - Otherwise next state EXEC.
- EXEC:
  - ALUOp, ALUSrc and EXTOp are driven per instruction.
  - Immediate extension: addi, addiu, slti, sltiu and loads/stores sign-extend; andi, ori, xori and lui zero-extend.
  - R-type ALU ops and ALU-immediate ops go to WB.
  - beq/bne: ALUOp=SUB; PCWrite=(beq&Zero)|(bne&~Zero), NPCOp=01; instr_done=1; next state FETCH.
  - j: PCWrite=1, NPCOp=10, instr_done=1; next state FETCH.
  - jal: PCWrite=1, NPCOp=10; next state WB.
  - jr: PCWrite=1, NPCOp=11, instr_done=1; next state FETCH.
  - jalr: PCWrite=1, NPCOp=11; next state WB.
  - lw/lb/lbu/lh/lhu/sw/sb/sh: ALUOp=ADD, ALUSrc=1; next state MEM.
- MEM:
  - dm_req=1, with MemWrite=1 for stores. ALU controls are held as in EXEC.
  - The FSM holds until dm_rdy=1.
  - On dm_rdy, stores: instr_done=1, next state FETCH. Loads: next state WB.
- WB:
  - RegWrite=1 for one cycle; next state FETCH; instr_done=1.
  - GPRSel/WDSel: R-type ALU ops use rd/ALU; immediate ALU ops use rt/ALU; loads use rt/MEM; jal uses r31/PC; jalr uses rd/PC.
- Writes to register 0 are not suppressed here; that is the register file's responsibility.
- The PC written in FETCH is PC+4. Branch and jump targets in EXEC are computed from that updated PC.
- Latency with zero wait states:
  - ALU ops: 4 cycles (FETCH to WB).
  - Loads: 5 cycles.
  - Stores: 4 cycles.
  - beq/bne/j/jr: 3 cycles.
  - jal/jalr: 4 cycles.
  - Each wait cycle adds one cycle.
- Outputs are Moore-style, decoded from state and Op/Funct. im_rdy, dm_rdy and Zero gate only the strobes in their own state.
- retired increments on every instr_done and wraps modulo 2^CNT_W. An illegal instruction also counts.
- Handshake edge cases:
  - im_rdy or dm_rdy asserted outside FETCH/MEM is ignored.
  - A ready that arrives in the same cycle as the request completes in that cycle.
- Reset asserted mid-instruction returns to IDLE immediately. No partial write completes after rstn falls.

Test Plan:
1. Reset release with im_rdy=1 tied: IDLE for 1 cycle; im_req first high in cycle 1; addu (Op=0, Funct=0x21) gives RegWrite in cycle 4 with ALUOp=01, GPRSel=00, WDSel=00; retired=1.
2. lw (Op=0x23) with dm_rdy delayed 3 cycles: dm_req high for 4 cycles, MemWrite=0; WB RegWrite=1 with GPRSel=01, WDSel=01; total 8 cycles.
3. beq (Op=0x04): Zero=1 gives PCWrite=1, NPCOp=01 in EXEC. Zero=0 gives PCWrite=0 and FETCH next. bne is checked with the inverse; 3 cycles each.
4. jal (Op=0x03): EXEC PCWrite=1, NPCOp=10; WB RegWrite=1, GPRSel=10, WDSel=10. jr (Funct=0x08): NPCOp=11, no RegWrite.
5. Op=0x3F: illegal and instr_done pulse in DECODE, no RegWrite/PCWrite/dm_req, FETCH next; retired increments.
6. rstn pulsed low during MEM of sw with dm_req high: dm_req and MemWrite drop asynchronously, state=0, retired=0; normal fetch resumes after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB and decodes datapath controls from Op/Funct.
// Outputs are decoded from state (and im_rdy/dm_rdy/Zero in their own state); memory wait states stall FETCH/MEM.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             im_rdy,
  input  logic             dm_rdy,
  output logic             im_req,
  output logic             dm_req,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       NPCOp,
  output logic             RegWrite,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             EXTOp,
  output logic             ALUSrc,
  output logic [5:0]       ALUOp,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_RALU, K_IALU, K_LOAD, K_STORE, K_BEQ, K_BNE,
    K_J, K_JAL, K_JR, K_JALR, K_BAD
  } kind_t;

  localparam logic [5:0] ALU_NOP  = 6'h00;
  localparam logic [5:0] ALU_ADD  = 6'h01;
  localparam logic [5:0] ALU_SUB  = 6'h02;
  localparam logic [5:0] ALU_AND  = 6'h03;
  localparam logic [5:0] ALU_OR   = 6'h04;
  localparam logic [5:0] ALU_SLT  = 6'h05;
  localparam logic [5:0] ALU_SLTU = 6'h06;
  localparam logic [5:0] ALU_XOR  = 6'h07;
  localparam logic [5:0] ALU_NOR  = 6'h08;
  localparam logic [5:0] ALU_SLL  = 6'h09;
  localparam logic [5:0] ALU_SRL  = 6'h0A;
  localparam logic [5:0] ALU_SLLV = 6'h0B;
  localparam logic [5:0] ALU_SRLV = 6'h0C;
  localparam logic [5:0] ALU_SRAV = 6'h0D;
  localparam logic [5:0] ALU_LUI  = 6'h0E;
  localparam logic [5:0] ALU_SRA  = 6'h11;

  state_t     cur, nxt;
  kind_t      kind;
  logic [5:0] alu_op_d;
  logic       alu_src_d, ext_op_d;

  // Instruction class and ALU controls, valid whenever the IR is stable.
  always_comb begin
    kind      = K_BAD;
    alu_op_d  = ALU_NOP;
    alu_src_d = 1'b0;
    ext_op_d  = 1'b0;
    case (Op)
      6'h00: begin
        kind = K_RALU;
        case (Funct)
          6'h20, 6'h21: alu_op_d = ALU_ADD;
          6'h22, 6'h23: alu_op_d = ALU_SUB;
          6'h24:        alu_op_d = ALU_AND;
          6'h25:        alu_op_d = ALU_OR;
          6'h26:        alu_op_d = ALU_XOR;
          6'h27:        alu_op_d = ALU_NOR;
          6'h2A:        alu_op_d = ALU_SLT;
          6'h2B:        alu_op_d = ALU_SLTU;
          6'h00:        alu_op_d = ALU_SLL;
          6'h02:        alu_op_d = ALU_SRL;
          6'h03:        alu_op_d = ALU_SRA;
          6'h04:        alu_op_d = ALU_SLLV;
          6'h06:        alu_op_d = ALU_SRLV;
          6'h07:        alu_op_d = ALU_SRAV;
          6'h08:        kind = K_JR;
          6'h09:        kind = K_JALR;
          default:      kind = K_BAD;
        endcase
      end
      6'h08, 6'h09: begin kind = K_IALU; alu_op_d = ALU_ADD;  alu_src_d = 1'b1; ext_op_d = 1'b1; end
      6'h0A:        begin kind = K_IALU; alu_op_d = ALU_SLT;  alu_src_d = 1'b1; ext_op_d = 1'b1; end
      6'h0B:        begin kind = K_IALU; alu_op_d = ALU_SLTU; alu_src_d = 1'b1; ext_op_d = 1'b1; end
      6'h0C:        begin kind = K_IALU; alu_op_d = ALU_AND;  alu_src_d = 1'b1; end
      6'h0D:        begin kind = K_IALU; alu_op_d = ALU_OR;   alu_src_d = 1'b1; end
      6'h0E:        begin kind = K_IALU; alu_op_d = ALU_XOR;  alu_src_d = 1'b1; end
      6'h0F:        begin kind = K_IALU; alu_op_d = ALU_LUI;  alu_src_d = 1'b1; end
      6'h04:        begin kind = K_BEQ;  alu_op_d = ALU_SUB; end
      6'h05:        begin kind = K_BNE;  alu_op_d = ALU_SUB; end
      6'h02:        kind = K_J;
      6'h03:        kind = K_JAL;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        kind = K_LOAD;  alu_op_d = ALU_ADD; alu_src_d = 1'b1; ext_op_d = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        kind = K_STORE; alu_op_d = ALU_ADD; alu_src_d = 1'b1; ext_op_d = 1'b1;
      end
      default: kind = K_BAD;
    endcase
  end

  always_comb begin
    nxt        = cur;
    im_req     = 1'b0;
    dm_req     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    NPCOp      = 2'b00;
    RegWrite   = 1'b0;
    GPRSel     = 2'b00;
    WDSel      = 2'b00;
    EXTOp      = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = ALU_NOP;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // ALU controls stay up through MEM/WB so the address/result path is stable.
    if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
      ALUOp  = alu_op_d;
      ALUSrc = alu_src_d;
      EXTOp  = ext_op_d;
    end
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        im_req = 1'b1;
        if (im_rdy) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (kind == K_BAD) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind)
          K_RALU, K_IALU:  nxt = S_WB;
          K_LOAD, K_STORE: nxt = S_MEM;
          K_BEQ, K_BNE: begin
            PCWrite    = (kind == K_BEQ) ? Zero : ~Zero;
            NPCOp      = 2'b01;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          K_J:    begin PCWrite = 1'b1; NPCOp = 2'b10; instr_done = 1'b1; nxt = S_FETCH; end
          K_JAL:  begin PCWrite = 1'b1; NPCOp = 2'b10; nxt = S_WB; end
          K_JR:   begin PCWrite = 1'b1; NPCOp = 2'b11; instr_done = 1'b1; nxt = S_FETCH; end
          K_JALR: begin PCWrite = 1'b1; NPCOp = 2'b11; nxt = S_WB; end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        dm_req   = 1'b1;
        MemWrite = (kind == K_STORE);
        if (dm_rdy) begin
          if (kind == K_STORE) begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
        case (kind)
          K_IALU:  begin GPRSel = 2'b01; WDSel = 2'b00; end
          K_LOAD:  begin GPRSel = 2'b01; WDSel = 2'b01; end
          K_JAL:   begin GPRSel = 2'b10; WDSel = 2'b10; end
          K_JALR:  begin GPRSel = 2'b00; WDSel = 2'b10; end
          default: begin GPRSel = 2'b00; WDSel = 2'b00; end
        endcase
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur     <= S_IDLE;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table of instructions with expected control behaviour, scoreboarded per instruction,
// plus hand sequences for reset release and reset during a store's MEM phase.
module tb_mc_ctrl;

  logic        clk, rstn;
  logic [5:0]  Op, Funct;
  logic        Zero, im_rdy, dm_rdy;
  logic        im_req, dm_req, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0]  NPCOp, GPRSel, WDSel;
  logic        EXTOp, ALUSrc;
  logic [5:0]  ALUOp;
  logic [2:0]  state;
  logic        instr_done, illegal;
  logic [31:0] retired;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .im_rdy(im_rdy), .dm_rdy(dm_rdy), .im_req(im_req), .dm_req(dm_req),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp),
    .RegWrite(RegWrite), .GPRSel(GPRSel), .WDSel(WDSel), .EXTOp(EXTOp),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .state(state), .instr_done(instr_done),
    .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         imw;
    int         dmw;
    int         cyc;
    logic [5:0] alu;
    logic       src;
    logic       ext;
    logic       rw;
    logic [1:0] gpr;
    logic [1:0] wd;
    logic       pcw;
    logic [1:0] npc;
    logic       ill;
    int         dmreq;
    logic       mw;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Runs one instruction from FETCH to its instr_done cycle; readies are held high
  // in every other state to show they are ignored there.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int cyc = 0, iw = 0, dw = 0, irw = 0, imreq = 0, dmr = 0, rwc = 0, illc = 0, pcwc = 0;
    logic mw = 1'b0, pcw = 1'b0, src = 1'b0, ext = 1'b0, done = 1'b0;
    logic [1:0] npc = 2'b00, gpr = 2'b00, wd = 2'b00;
    logic [5:0] alu_ex = 6'h00, alu_wb = 6'h00, alu_mem = 6'h00;
    exp_q.push_back(v);
    Op = v.op; Funct = v.funct; Zero = v.zero;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      im_rdy = 1'b1;
      dm_rdy = 1'b1;
      if (state == 3'd1) begin im_rdy = (iw >= v.imw); iw++; end
      if (state == 3'd4) begin dm_rdy = (dw >= v.dmw); dw++; end
      #1;
      if (state != 3'd0) cyc++;
      if (IRWrite)  irw++;
      if (im_req)   imreq++;
      if (dm_req)   dmr++;
      if (MemWrite) mw = 1'b1;
      if (illegal)  illc++;
      if (PCWrite)  pcwc++;
      if (RegWrite) begin rwc++; gpr = GPRSel; wd = WDSel; alu_wb = ALUOp; end
      if (state == 3'd3) begin
        pcw = PCWrite; npc = NPCOp; alu_ex = ALUOp; src = ALUSrc; ext = EXTOp;
      end
      if (state == 3'd4) alu_mem = ALUOp;
      if (instr_done) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL v%0d timeout waiting for instr_done state=%0d", idx, state);
      e = exp_q.pop_front();
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d cycles", idx),    cyc,    e.cyc);
    chk($sformatf("v%0d im_req", idx),    imreq,  1 + e.imw);
    chk($sformatf("v%0d IRWrite", idx),   irw,    1);
    chk($sformatf("v%0d ALUOp", idx),     alu_ex, (e.ill ? 6'h00 : e.alu));
    chk($sformatf("v%0d ALUSrc", idx),    src,    e.src);
    chk($sformatf("v%0d EXTOp", idx),     ext,    e.ext);
    chk($sformatf("v%0d exec_PCWrite", idx), pcw, e.pcw);
    chk($sformatf("v%0d NPCOp", idx),     npc,    e.npc);
    chk($sformatf("v%0d PCWrite_cnt", idx), pcwc, 1 + (e.pcw ? 1 : 0));
    chk($sformatf("v%0d RegWrite", idx),  rwc,    e.rw ? 1 : 0);
    chk($sformatf("v%0d GPRSel", idx),    gpr,    e.gpr);
    chk($sformatf("v%0d WDSel", idx),     wd,     e.wd);
    chk($sformatf("v%0d wb_ALUOp", idx),  alu_wb, (e.rw ? e.alu : 6'h00));
    chk($sformatf("v%0d dm_req", idx),    dmr,    e.dmreq);
    chk($sformatf("v%0d mem_ALUOp", idx), alu_mem, (e.dmreq > 0 ? e.alu : 6'h00));
    chk($sformatf("v%0d MemWrite", idx),  mw,     e.mw);
    chk($sformatf("v%0d illegal", idx),   illc,   e.ill ? 1 : 0);
    exp_retired++;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d retired", idx),   retired, exp_retired);
    chk($sformatf("v%0d next_state", idx), state,  3'd1);
  endtask

  initial begin
    //          op     funct  z     imw dmw cyc alu    src   ext   rw    gpr    wd     pcw   npc    ill  dmreq mw
    vecs[0]  = '{6'h00, 6'h21, 1'b0, 0, 0, 4, 6'h01, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // addu
    vecs[1]  = '{6'h23, 6'h00, 1'b0, 0, 3, 8, 6'h01, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 4, 1'b0}; // lw, 3 waits
    vecs[2]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3, 6'h02, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0, 0, 1'b0}; // beq taken
    vecs[3]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 6'h02, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 1'b0, 0, 1'b0}; // beq not taken
    vecs[4]  = '{6'h05, 6'h00, 1'b0, 0, 0, 3, 6'h02, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0, 0, 1'b0}; // bne taken
    vecs[5]  = '{6'h05, 6'h00, 1'b1, 0, 0, 3, 6'h02, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 1'b0, 0, 1'b0}; // bne not taken
    vecs[6]  = '{6'h03, 6'h00, 1'b0, 0, 0, 4, 6'h00, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 2'd2, 1'b0, 0, 1'b0}; // jal
    vecs[7]  = '{6'h00, 6'h08, 1'b0, 0, 0, 3, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 1'b0, 0, 1'b0}; // jr
    vecs[8]  = '{6'h00, 6'h09, 1'b0, 0, 0, 4, 6'h00, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 2'd3, 1'b0, 0, 1'b0}; // jalr
    vecs[9]  = '{6'h3F, 6'h00, 1'b0, 0, 0, 2, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 0, 1'b0}; // bad Op
    vecs[10] = '{6'h00, 6'h3F, 1'b0, 0, 0, 2, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 0, 1'b0}; // bad Funct
    vecs[11] = '{6'h2B, 6'h00, 1'b0, 0, 2, 6, 6'h01, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 3, 1'b1}; // sw, 2 waits
    vecs[12] = '{6'h08, 6'h00, 1'b0, 2, 0, 6, 6'h01, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // addi, 2 fetch waits
    vecs[13] = '{6'h0D, 6'h00, 1'b0, 0, 0, 4, 6'h04, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // ori
    vecs[14] = '{6'h0F, 6'h00, 1'b0, 0, 0, 4, 6'h0E, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // lui
    vecs[15] = '{6'h00, 6'h03, 1'b0, 0, 0, 4, 6'h11, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // sra
    vecs[16] = '{6'h00, 6'h2A, 1'b0, 0, 0, 4, 6'h05, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // slt
    vecs[17] = '{6'h02, 6'h00, 1'b0, 0, 0, 3, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0, 0, 1'b0}; // j
    vecs[18] = '{6'h24, 6'h00, 1'b0, 0, 0, 5, 6'h01, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 1, 1'b0}; // lbu
    vecs[19] = '{6'h0B, 6'h00, 1'b0, 0, 0, 4, 6'h06, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // sltiu
    vecs[20] = '{6'h00, 6'h23, 1'b1, 0, 0, 4, 6'h02, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // subu, Zero ignored
    vecs[21] = '{6'h00, 6'h27, 1'b0, 1, 0, 5, 6'h08, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // nor, 1 fetch wait

    // Reset held with readies tied high: everything must stay quiet.
    rstn = 1'b0; Op = 6'h00; Funct = 6'h21; Zero = 1'b1; im_rdy = 1'b1; dm_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", {im_req, dm_req, MemWrite, IRWrite, PCWrite, NPCOp, RegWrite, GPRSel,
                          WDSel, EXTOp, ALUSrc, ALUOp, state, instr_done, illegal}, 32'd0);
    chk("reset retired", retired, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("idle state", state, 3'd0);
    chk("idle im_req", im_req, 1'b0);
    @(posedge clk);
    #1;
    chk("first fetch state", state, 3'd1);
    chk("first fetch im_req", im_req, 1'b1);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset during a stalled store: request must drop immediately and the count clear.
    begin
      logic hit;
      hit = 1'b0;
      Op = 6'h2B; Funct = 6'h00; Zero = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        @(negedge clk);
        im_rdy = 1'b1;
        dm_rdy = 1'b0;
        #1;
        if (state == 3'd4) hit = 1'b1;
      end
      if (!hit) begin
        checks++;
        failures++;
        $display("FAIL sw_mem timeout waiting for MEM state=%0d", state);
      end else begin
        chk("sw_mem dm_req", dm_req, 1'b1);
        chk("sw_mem MemWrite", MemWrite, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midreset dm_req", dm_req, 1'b0);
        chk("midreset MemWrite", MemWrite, 1'b0);
        chk("midreset state", state, 3'd0);
        chk("midreset retired", retired, 32'd0);
      end
      exp_retired = 0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      run_vec(100, vecs[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
